// File: rtl/cl_pkg.sv
// Shared definitions for the multi-cycle control sequencer:
// opcode values, FSM state encoding, instruction field positions
// and the decoded control bundle.
package cl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int WREG_MSB  = 11;
  localparam int WREG_LSB  = 9;
  localparam int RREG1_MSB = 8;
  localparam int RREG1_LSB = 6;
  localparam int RREG2_MSB = 5;
  localparam int RREG2_LSB = 3;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;

  typedef struct packed {
    logic src2_sel;
    logic alu_out_sel;
    logic is_mem;
    logic is_st;
    logic is_wb;
    logic is_jmp;
    logic is_br;
    logic is_halt;
  } ctrl_t;

endpackage

// File: rtl/cl_decode.sv
// Opcode decoder: turns the 4-bit opcode into the mux selects and the
// instruction-class flags the sequencer steers on. Codes A-E decode as NOP.
module cl_decode import cl_pkg::*; (
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  // Classify the opcode; everything not listed stays all-zero (NOP).
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.is_wb = 1'b1;
      end
      OP_ADDI: begin
        ctrl.src2_sel = 1'b1;
        ctrl.is_wb    = 1'b1;
      end
      OP_LD: begin
        ctrl.src2_sel    = 1'b1;
        ctrl.alu_out_sel = 1'b1;
        ctrl.is_mem      = 1'b1;
        ctrl.is_wb       = 1'b1;
      end
      OP_ST: begin
        ctrl.src2_sel = 1'b1;
        ctrl.is_mem   = 1'b1;
        ctrl.is_st    = 1'b1;
      end
      OP_JMP:  ctrl.is_jmp  = 1'b1;
      OP_BEQZ: ctrl.is_br   = 1'b1;
      OP_HALT: ctrl.is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cl_seq_fsm.sv
// Multi-cycle control sequencer. Owns PC and IR and walks each instruction
// through FETCH / DECODE / EXEC / (MEM) / (WB), handshaking with instruction
// and data memories of arbitrary latency. Field outputs and selects come
// straight from IR, so they hold from DECODE until the next IR load.
module cl_seq_fsm import cl_pkg::*; #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  input  logic            alu_zero,
  output logic [3:0]      OPCODE,
  output logic [2:0]      Wreg_Sig,
  output logic [2:0]      Rreg_Sig1,
  output logic [2:0]      Rreg_Sig2,
  output logic [5:0]      Immediate_Addr,
  output logic            Source2_select,
  output logic            ALU_out_Select,
  output logic            reg_we,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [15:0]     ir, ir_next;
  logic            started;
  ctrl_t           ctrl;
  logic [PC_W-1:0] target;

  cl_decode u_decode (
    .opcode (ir[OPC_MSB:OPC_LSB]),
    .ctrl   (ctrl)
  );

  assign target         = ir[PC_W-1:0];
  assign instr_addr     = pc;
  assign OPCODE         = ir[OPC_MSB:OPC_LSB];
  assign Wreg_Sig       = ir[WREG_MSB:WREG_LSB];
  assign Rreg_Sig1      = ir[RREG1_MSB:RREG1_LSB];
  assign Rreg_Sig2      = ir[RREG2_MSB:RREG2_LSB];
  assign Immediate_Addr = ir[IMM_MSB:IMM_LSB];
  assign Source2_select = ctrl.src2_sel;
  assign ALU_out_Select = ctrl.alu_out_sel;

  // State, PC and IR registers; 'started' keeps imem_req low until the
  // first clock edge after reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      started <= 1'b1;
    end
  end

  // Next-state, PC/IR update and handshake/strobe outputs.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_we     = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = started;
        if (imem_req && imem_ack) begin
          ir_next    = imem_rdata;
          pc_next    = pc + PC_W'(1);
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (ctrl.is_halt) begin
          state_next = S_HALT;
        end else if (ctrl.is_jmp) begin
          pc_next    = target;
          state_next = S_FETCH;
        end else if (ctrl.is_br) begin
          if (alu_zero) pc_next = target;
          state_next = S_FETCH;
        end else if (ctrl.is_mem) begin
          state_next = S_MEM;
        end else if (ctrl.is_wb) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl.is_st;
        if (dmem_ack) state_next = ctrl.is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/cl_seq_fsm.md
Name: cl_seq_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit custom processor.
- Owns the PC and instruction register. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the register-file selects, the ALU mux selects and the instruction/data memory request handshakes.
- Sits between the instruction memory, data memory, register file and ALU. It replaces the single-cycle control logic when memories have variable latency.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- PC_W, 8, PC/instruction address width. Jump target is IR[PC_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- instr_addr  out  PC_W  current PC, presented to instruction memory.
- imem_rdata  in  16  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete; honoured only while imem_req=1.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_ack  in  1  data access complete; honoured only while dmem_req=1.
- alu_zero  in  1  ALU result == 0; sampled in EXEC.
- OPCODE  out  4  IR[15:12].
- Wreg_Sig  out  3  IR[11:9], destination register.
- Rreg_Sig1  out  3  IR[8:6].
- Rreg_Sig2  out  3  IR[5:3].
- Immediate_Addr  out  6  IR[5:0].
- Source2_select  out  1  1 = immediate to ALU B (ADDI, LD, ST).
- ALU_out_Select  out  1  1 = writeback data from memory (LD).
- reg_we  out  1  register-file write strobe, one cycle in WB.
- halted  out  1  1 in HALT state.

Behaviour:
- Reset is asynchronous and active-low. Assertion at any time, including mid-handshake, forces:
  - state=FETCH, PC=RESET_PC, IR=16'h0000;
  - all req/we/select/strobe outputs = 0;
  - halted=0.
- After rstn deasserts, imem_req rises on the first clock edge.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDI, 6 LD, 7 ST, 8 JMP, 9 BEQZ, F HALT. Codes A–E are NOPs.
- FETCH:
  - imem_req=1, held stable until imem_ack.
  - On the ack edge: IR<=imem_rdata, PC<=PC+1 (wraps FF->00), go to DECODE. imem_req drops the same edge.
- DECODE: exactly 1 cycle. Field outputs reflect the new IR; selects are set from the opcode.
- EXEC: exactly 1 cycle.
  - JMP: PC<=IR[7:0], go to FETCH.
  - BEQZ: if alu_zero=1 then PC<=IR[7:0]; go to FETCH.
  - LD/ST: go to MEM.
  - ALU/ADDI: go to WB.
  - NOP: go to FETCH.
  - HALT: go to HALT.
- MEM:
  - dmem_req=1; dmem_we=1 for ST.
  - Hold until dmem_ack, then LD goes to WB and ST goes to FETCH.
- WB: reg_we=1 for exactly 1 cycle, then FETCH.
- HALT: all requests 0, halted=1. Only rstn exits this state.
- Field outputs and selects stay stable from DECODE until the next IR load.
- Minimum cycles per instruction, with single-cycle ack:
  - ALU: 4
  - LD: 5
  - ST: 4
  - JMP/BEQZ/NOP: 3
- An ack arriving while the matching req=0 is ignored.
- An ack in the same cycle req first rises is accepted.

Decomposition:
- cl_pkg holds:
  - the opcode localparams (OP_ADD..OP_HALT);
  - the state encoding (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, 3-bit);
  - the field-slice constants.
- One sub-module is natural: cl_decode.
  - Purely combinational, opcode -> {Source2_select, ALU_out_Select, is_mem, is_st, is_wb, is_jmp, is_br, is_halt}.
  - cl_seq_fsm holds all state, PC and IR.

Test Plan:
- Reset/first fetch: hold rstn=0 for 3 clocks, then release. Require instr_addr=00 with all outputs 0 while in reset, and imem_req=1 on the first edge after release.
- ADD, imem_rdata=16'h0298 (rd=1, rs1=2, rs2=3) with zero-wait ack:
  - DECODE shows OPCODE=0, Wreg=1, Rreg1=2, Rreg2=3;
  - reg_we pulses exactly on cycle 4;
  - next fetch address is 01.
- LD with dmem_ack delayed 3 cycles: dmem_req held 4 cycles with dmem_we=0, then ALU_out_Select=1 and one reg_we pulse. ST: dmem_we=1, no reg_we.
- JMP 16'h80A5 at PC=FE: next instr_addr=A5. BEQZ with alu_zero=0 falls through to PC+1; with alu_zero=1 it loads IR[7:0]. PC at FF with NOP wraps to 00.
- Reset mid-MEM (rstn low while dmem_req=1): dmem_req drops asynchronously, and state/PC restart at FETCH/00.
- HALT 16'hF000: halted=1, no further req for 20 cycles, acks ignored. Reset clears halted.
